riscv_v_reduct_acc: RTL and testbench
=====================================

RISCV_V_REDUCT_ACC -- requirements
Module: riscv_v_reduct_acc

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16: bytes per beat in the vector ALU byte-vector result.
REQ-002 SHALL have parameter MAX_BEATS, default 8: maximum beats per reduction (LMUL 8).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1: beat present.
REQ-006 SHALL have port in_ready, output, 1: beat accepted when in_valid & in_ready.
REQ-007 SHALL have port in_data, input, NUM_BYTES*8: bitwise-reduction byte vector; the reduced element sits in the low bytes.
REQ-008 SHALL have port in_byte_valid, input, NUM_BYTES: per-byte valid.
REQ-009 SHALL have port in_osize, input, 2: element size, 00 byte, 01 half, 10 word, 11 dword.
REQ-010 SHALL have port in_op, input, 2: 00 OR, 01 AND, 10 XOR, 11 reserved.
REQ-011 SHALL have port in_first, input, 1: first beat of a reduction.
REQ-012 SHALL have port in_last, input, 1: last beat of a reduction.
REQ-013 SHALL have port out_valid, output, 1: final scalar result available.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-015 SHALL have port out_data, output, 64: final scalar, zero-extended above the element width.
REQ-016 SHALL have port out_osize, output, 2: element size latched for the result.
REQ-017 SHALL have port err_seq, output, 1: sticky protocol error flag.

Function
REQ-018 SHALL implement states IDLE, ACCUM and HOLD; in_ready = 1 in IDLE and ACCUM and 0 in HOLD.
REQ-019 SHALL extract the beat element as the low 2^in_osize bytes of in_data; any byte with in_byte_valid = 0 SHALL be replaced by the op identity (0x00 for OR/XOR, 0xFF for AND).
REQ-020 SHALL, on an accepted first beat, load acc = element, latch op/osize, set beat count = 1, and go to ACCUM (or to HOLD if in_last is also 1).
REQ-021 SHALL, on an accepted non-first beat in ACCUM, set acc = acc op element using the latched op/osize (beat op/osize ignored) and increment the beat count.
REQ-022 SHALL, on an accepted in_last, go to HOLD; out_valid SHALL rise the cycle after that acceptance (latency 1).
REQ-023 SHALL, in HOLD, keep out_data/out_osize stable while out_valid is 1 and out_ready is 0; on out_valid & out_ready it SHALL go to IDLE, with out_valid 0 the next cycle.
REQ-024 SHALL mask out_data to the element width, with bits above it set to 0.
REQ-025 SHALL, when a beat is accepted in IDLE without in_first, drop the beat and set err_seq.
REQ-026 SHALL, when in_first is accepted in ACCUM, restart the accumulation with that beat and set err_seq.
REQ-027 SHALL, when a non-last beat would bring the count to MAX_BEATS, treat it as the last beat, go to HOLD, and set err_seq.
REQ-028 SHALL, for in_op = 11 on a first beat, drop the beat, stay in IDLE, and set err_seq.
REQ-029 SHALL have no combinational path from in_* to out_*.

Reset
REQ-030 SHALL, on rst = 1 at a clock edge, go to IDLE with out_valid = 0, out_data = 0, out_osize = 00, err_seq = 0, acc = 0 and beat count = 0; rst SHALL override any simultaneous handshake.
REQ-031 SHALL, on reset mid-ACCUM or mid-HOLD, discard the partial or pending result without asserting out_valid.

Configuration
REQ-032 SHALL, when RISCV_V_REDUCT_ACC_XOR_EN is defined, support XOR (in_op = 10) as specified.
REQ-033 SHALL, without RISCV_V_REDUCT_ACC_XOR_EN, handle in_op = 10 exactly like the reserved op 11 (REQ-028); the OR and AND paths SHALL be unchanged.

Verification
REQ-034 SHALL check single beat, OR, osize=10, in_data low word 0x0000_00F0, first=last=1 -> out_valid next cycle with out_data 0x0000_0000_0000_00F0 and out_osize 10.
REQ-035 SHALL check 4 beats, AND, osize=00, low bytes FF, 7F, 3F, 1F -> out_data 0x1F after the last beat, err_seq 0.
REQ-036 SHALL check 2 beats, OR, osize=01, beat 2 with byte_valid[1]=0 and data 0xAB12 after beat 1 = 0x0100 -> out_data 0x0112.
REQ-037 SHALL check out_ready held 0 for 5 cycles in HOLD -> out_valid and out_data stable and in_ready 0; out_ready=1 -> IDLE next cycle.
REQ-038 SHALL check a beat without first in IDLE -> err_seq = 1 and out_valid stays 0; then 8 non-last beats -> forced HOLD after beat 8.
REQ-039 SHALL check rst in ACCUM after 3 beats -> next cycle out_valid 0, err_seq 0, and a fresh single-beat reduction producing the correct value.

Source files
------------

// File: rtl/riscv_v_reduct_acc.sv
// Multi-beat bitwise reduction accumulator (OR/AND, XOR when RISCV_V_REDUCT_ACC_XOR_EN is defined)
// for vector ALU byte-vector results; emits one zero-extended scalar per reduction.
module riscv_v_reduct_acc #(
  parameter int NUM_BYTES = 16,
  parameter int MAX_BEATS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_BYTES*8-1:0] in_data,
  input  logic [NUM_BYTES-1:0]   in_byte_valid,
  input  logic [1:0]             in_osize,
  input  logic [1:0]             in_op,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_data,
  output logic [1:0]             out_osize,
  output logic                   err_seq
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  function automatic logic op_ok(input logic [1:0] op);
`ifdef RISCV_V_REDUCT_ACC_XOR_EN
    return (op == OP_OR) || (op == OP_AND) || (op == OP_XOR);
`else
    return (op == OP_OR) || (op == OP_AND);
`endif
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] os);
    case (os)
      2'b00:   return 64'h0000_0000_0000_00FF;
      2'b01:   return 64'h0000_0000_0000_FFFF;
      2'b10:   return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] op_apply(input logic [1:0] op, input logic [63:0] a,
                                           input logic [63:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

  state_t          r_state, w_state_next;
  logic [63:0]     r_acc, w_acc_next;
  logic [1:0]      r_op, w_op_next;
  logic [1:0]      r_osize, w_osize_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_out_valid, w_out_valid_next;
  logic [63:0]     r_out_data, w_out_data_next;
  logic [1:0]      r_out_osize, w_out_osize_next;
  logic            r_err, w_err_next;

  logic            w_accept;
  logic            w_load, w_step;
  logic [63:0]     w_fold;
  logic [CW-1:0]   w_new_cnt;
  logic [1:0]      w_fin_osize;
  logic [1:0]      w_eop, w_eosize;
  logic [63:0]     w_emask;
  logic [7:0]      w_ident;
  logic [63:0]     w_elem;

  assign in_ready = (r_state != HOLD);
  assign w_accept = in_valid & in_ready;

  // A continuing beat is shaped by the op/size latched at its first beat.
  assign w_eop    = (r_state == ACCUM && !in_first) ? r_op : in_op;
  assign w_eosize = (r_state == ACCUM && !in_first) ? r_osize : in_osize;
  assign w_emask  = size_mask(w_eosize);
  assign w_ident  = (w_eop == OP_AND) ? 8'hFF : 8'h00;

  for (genvar gi = 0; gi < 8; gi++) begin : g_elem
    if (gi < NUM_BYTES) begin : g_byte
      assign w_elem[gi*8 +: 8] = !w_emask[gi*8] ? 8'h00 :
                                 (in_byte_valid[gi] ? in_data[gi*8 +: 8] : w_ident);
    end else begin : g_pad
      assign w_elem[gi*8 +: 8] = 8'h00;
    end
  end

  if (NUM_BYTES > 8) begin : g_hi
    logic w_unused_hi;
    assign w_unused_hi = ^{in_data[NUM_BYTES*8-1:64], in_byte_valid[NUM_BYTES-1:8]};
  end

  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_op_next        = r_op;
    w_osize_next     = r_osize;
    w_cnt_next       = r_cnt;
    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;
    w_out_osize_next = r_out_osize;
    w_err_next       = r_err;
    w_load           = 1'b0;
    w_step           = 1'b0;
    w_fold           = 64'h0;
    w_new_cnt        = '0;
    w_fin_osize      = r_osize;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!in_first || !op_ok(in_op)) w_err_next = 1'b1;
          else                            w_load     = 1'b1;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          if (in_first) begin
            w_err_next = 1'b1;
            if (op_ok(in_op)) begin
              w_load = 1'b1;
            end else begin
              w_state_next = IDLE;
              w_acc_next   = 64'h0;
              w_cnt_next   = '0;
            end
          end else begin
            w_step = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_next     = IDLE;
          w_out_valid_next = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase

    if (w_load || w_step) begin
      w_fold       = w_load ? w_elem : op_apply(r_op, r_acc, w_elem);
      w_new_cnt    = w_load ? CW'(1) : r_cnt + CW'(1);
      w_fin_osize  = w_load ? in_osize : r_osize;
      w_acc_next   = w_fold;
      w_cnt_next   = w_new_cnt;
      w_osize_next = w_fin_osize;
      if (w_load) w_op_next = in_op;
      // Hitting the beat limit without in_last closes the reduction as an error.
      if (in_last || w_new_cnt == CW'(MAX_BEATS)) begin
        w_state_next     = HOLD;
        w_out_valid_next = 1'b1;
        w_out_data_next  = w_fold & size_mask(w_fin_osize);
        w_out_osize_next = w_fin_osize;
        if (!in_last) w_err_next = 1'b1;
      end else begin
        w_state_next = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= 64'h0;
      r_op        <= 2'b00;
      r_osize     <= 2'b00;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 64'h0;
      r_out_osize <= 2'b00;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_op        <= w_op_next;
      r_osize     <= w_osize_next;
      r_cnt       <= w_cnt_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_out_osize <= w_out_osize_next;
      r_err       <= w_err_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_osize = r_out_osize;
  assign err_seq   = r_err;

endmodule

// File: tb/tb_riscv_v_reduct_acc.sv
// Directed plus randomized bench for riscv_v_reduct_acc against a byte-level reduction model.
module tb_riscv_v_reduct_acc;
  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_first, in_last;
  logic [NB*8-1:0] in_data;
  logic [NB-1:0]   in_byte_valid;
  logic [1:0]      in_osize, in_op, out_osize;
  logic            out_valid, out_ready, err_seq;
  logic [63:0]     out_data;

  int checks = 0;
  int failures = 0;

  riscv_v_reduct_acc #(.NUM_BYTES(NB), .MAX_BEATS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_byte_valid(in_byte_valid), .in_osize(in_osize),
    .in_op(in_op), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_osize(out_osize), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  // Element = low 2^os bytes, invalid bytes forced to the op identity, rest zero.
  function automatic logic [63:0] elem_of(input logic [127:0] d, input logic [15:0] bv,
                                          input logic [1:0] op, input logic [1:0] os);
    logic [63:0] e = 64'h0;
    for (int b = 0; b < (1 << os); b++)
      e[b*8 +: 8] = bv[b] ? d[b*8 +: 8] : ((op == 2'b01) ? 8'hFF : 8'h00);
    return e;
  endfunction

  function automatic logic [63:0] combine(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] op);
    if (op == 2'b01) return a & b;
    if (op == 2'b10) return a ^ b;
    return a | b;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d, input logic [15:0] bv, input logic [1:0] os,
                      input logic [1:0] op, input logic f, input logic l);
    in_valid = 1'b1; in_data = d; in_byte_valid = bv; in_osize = os; in_op = op;
    in_first = f; in_last = l;
    tick();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, out_valid, 1'b0);
    check({tag, "_rdy_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [127:0] d;
    logic [15:0]  bv;
    logic [1:0]   op, os, bop, bos;
    logic [63:0]  exp;
    int           n;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_byte_valid = '0; in_osize = 2'b00;
    in_op = 2'b00; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    do_reset();
    check("rst_ov", out_valid, 1'b0);
    check("rst_data", out_data, 64'h0);
    check("rst_osize", out_osize, 2'b00);
    check("rst_err", err_seq, 1'b0);
    check("rst_rdy", in_ready, 1'b1);

    // single beat OR word
    beat(128'hDEAD_BEEF_0000_00F0, 16'hFFFF, 2'b10, 2'b00, 1'b1, 1'b1);
    check("single_ov", out_valid, 1'b1);
    check("single_data", out_data, 64'h0000_0000_0000_00F0);
    check("single_osize", out_osize, 2'b10);
    check("single_rdy", in_ready, 1'b0);
    consume("single");

    // 4-beat AND byte
    exp = 64'hFF;
    for (int k = 0; k < 4; k++) begin
      d = {96'h0, $urandom};
      d[7:0] = 8'hFF >> k;
      exp = combine(exp, elem_of(d, 16'hFFFF, 2'b01, 2'b00), 2'b01);
      beat(d, 16'hFFFF, 2'b00, 2'b01, k == 0, k == 3);
    end
    check("and4_data", out_data, exp);
    check("and4_lit", out_data, 64'h1F);
    check("and4_err", err_seq, 1'b0);
    consume("and4");

    // 2-beat OR half with an invalid byte
    beat(128'h0100, 16'hFFFF, 2'b01, 2'b00, 1'b1, 1'b0);
    beat(128'hAB12, 16'hFFFD, 2'b01, 2'b00, 1'b0, 1'b1);
    check("half_data", out_data, 64'h0112);
    check("half_osize", out_osize, 2'b01);

    // backpressure in HOLD, with a competing beat offered
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_data = 128'h55; in_op = 2'b00;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold%0d_ov", c), out_valid, 1'b1);
      check($sformatf("hold%0d_data", c), out_data, 64'h0112);
      check($sformatf("hold%0d_rdy", c), in_ready, 1'b0);
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    consume("hold");

    // random reductions
    for (int r = 0; r < 25; r++) begin
`ifdef RISCV_V_REDUCT_ACC_XOR_EN
      op = 2'($urandom_range(0, 2));
`else
      op = 2'($urandom_range(0, 1));
`endif
      os = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 8);
      exp = 64'h0;
      for (int k = 0; k < n; k++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        bv = 16'($urandom);
        bop = (k == 0) ? op : 2'($urandom_range(0, 3));
        bos = (k == 0) ? os : 2'($urandom_range(0, 3));
        exp = (k == 0) ? elem_of(d, bv, op, os) : combine(exp, elem_of(d, bv, op, os), op);
        repeat ($urandom_range(0, 2)) tick();
        beat(d, bv, bos, bop, k == 0, k == n - 1);
      end
      check($sformatf("rnd%0d_ov", r), out_valid, 1'b1);
      check($sformatf("rnd%0d_data", r), out_data, exp);
      check($sformatf("rnd%0d_osize", r), out_osize, os);
      check($sformatf("rnd%0d_err", r), err_seq, 1'b0);
      repeat ($urandom_range(0, 3)) tick();
      check($sformatf("rnd%0d_stable", r), out_data, exp);
      consume($sformatf("rnd%0d", r));
    end

    // beat without first, then forced end after 8 non-last beats
    beat(128'h77, 16'hFFFF, 2'b00, 2'b00, 1'b0, 1'b0);
    check("nofirst_err", err_seq, 1'b1);
    check("nofirst_ov", out_valid, 1'b0);
    check("nofirst_rdy", in_ready, 1'b1);
    exp = 64'h0;
    for (int k = 0; k < 8; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      exp = combine(exp, elem_of(d, 16'hFFFF, 2'b00, 2'b11), 2'b00);
      beat(d, 16'hFFFF, 2'b11, 2'b00, k == 0, 1'b0);
      if (k < 7) check($sformatf("max_b%0d_ov", k), out_valid, 1'b0);
    end
    check("max_ov", out_valid, 1'b1);
    check("max_data", out_data, exp);
    check("max_rdy", in_ready, 1'b0);
    consume("max");

    // reserved op on a first beat
    do_reset();
    beat(128'h12, 16'hFFFF, 2'b00, 2'b11, 1'b1, 1'b1);
    check("rsv_err", err_seq, 1'b1);
    check("rsv_ov", out_valid, 1'b0);
    check("rsv_rdy", in_ready, 1'b1);
`ifdef RISCV_V_REDUCT_ACC_XOR_EN
    beat(128'hF0, 16'hFFFF, 2'b00, 2'b10, 1'b1, 1'b0);
    beat(128'h3C, 16'hFFFF, 2'b00, 2'b00, 1'b0, 1'b1);
    check("xor_data", out_data, 64'hCC);
    consume("xor");
`else
    do_reset();
    beat(128'h12, 16'hFFFF, 2'b00, 2'b10, 1'b1, 1'b1);
    check("xordis_err", err_seq, 1'b1);
    check("xordis_ov", out_valid, 1'b0);
`endif

    // first beat in ACCUM restarts
    do_reset();
    beat(128'h11, 16'hFFFF, 2'b00, 2'b00, 1'b1, 1'b0);
    beat(128'h3322, 16'hFFFF, 2'b00, 2'b01, 1'b1, 1'b1);
    check("restart_data", out_data, 64'h22);
    check("restart_err", err_seq, 1'b1);
    consume("restart");

    // reset mid-ACCUM with a simultaneous last beat; err_seq is set beforehand
    for (int k = 0; k < 3; k++) beat(128'hF00 >> k, 16'hFFFF, 2'b01, 2'b00, k == 0, 1'b0);
    rst = 1'b1;
    beat(128'hFFFF, 16'hFFFF, 2'b01, 2'b00, 1'b0, 1'b1);
    rst = 1'b0;
    check("rstacc_ov", out_valid, 1'b0);
    check("rstacc_err", err_seq, 1'b0);
    check("rstacc_rdy", in_ready, 1'b1);
    tick();
    check("rstacc_ov2", out_valid, 1'b0);
    beat(128'hC3A5, 16'hFFFE, 2'b01, 2'b01, 1'b1, 1'b1);
    check("rstacc_fresh", out_data, 64'hC3FF);

    // reset mid-HOLD discards the pending result
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rsthold_ov", out_valid, 1'b0);
    check("rsthold_data", out_data, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
